// File: rtl/lcd_pkg.sv
// Shared types, default timing constants and command classification for the LCD bus scheduler.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    POLL
  } state_t;

  localparam int T_SETUP_DEF     = 2;
  localparam int T_EN_HIGH_DEF   = 12;
  localparam int T_HOLD_DEF      = 2;
  localparam int T_EXEC_DEF      = 2000;
  localparam int T_EXEC_LONG_DEF = 82000;
  localparam int CNT_W_DEF       = 17;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter2.sv
// Two-way round-robin pick between LCD bus requesters; purely combinational.
module lcd_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] ack,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  logic [1:0] elig;

  // A requester being acked this cycle is not eligible, so it cannot be regranted immediately.
  assign elig  = req & ~ack;
  assign valid = |elig;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick = last;
    case (elig)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = last;
    endcase
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Arbitrates two byte-write clients onto one HD44780 bus and generates the E-strobe timing.
// Optional feature macro LCD_BUSY_POLL_EN: replace the fixed EXEC wait with busy-flag polling.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = T_SETUP_DEF,
  parameter int T_EN_HIGH   = T_EN_HIGH_DEF,
  parameter int T_HOLD      = T_HOLD_DEF,
  parameter int T_EXEC      = T_EXEC_DEF,
  parameter int T_EXEC_LONG = T_EXEC_LONG_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       grant_id,
  output logic       lcd_e,
  output logic       lcd_rs,
`ifdef LCD_BUSY_POLL_EN
  output logic       lcd_rw,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_in,
`endif
  output logic [7:0] lcd_db
);

  localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN        = CNT_W'(T_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic [1:0]       ack_q, ack_d;
  logic             gid_q, gid_d;
  logic             busy_q, busy_d;
  logic             cnt_last;
  logic             arb_valid, arb_pick;

`ifdef LCD_BUSY_POLL_EN
  logic             rd_q, rd_d;
  logic             stat_q, stat_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             rw_q, rw_d;
  logic             oe_q, oe_d;
`else
  logic             long_q, long_d;
`endif

  lcd_rr_arbiter2 u_arb (
    .req   ({req1, req0}),
    .ack   (ack_q),
    .last  (gid_q),
    .valid (arb_valid),
    .pick  (arb_pick)
  );

  assign cnt_last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    gid_d   = gid_q;
    ack_d   = 2'b00;
`ifdef LCD_BUSY_POLL_EN
    rd_d    = rd_q;
    stat_d  = stat_q;
    pcnt_d  = rd_q ? pcnt_q + 1'b1 : '0;
    rw_d    = rw_q;
    oe_d    = oe_q;
`else
    long_d  = long_q;
`endif

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gid_d   = arb_pick;
          rs_d    = arb_pick ? rs1 : rs0;
          db_d    = arb_pick ? data1 : data0;
`ifndef LCD_BUSY_POLL_EN
          long_d  = is_long_cmd(rs_d, db_d);
`endif
          cnt_d   = LD_SETUP;
          state_d = SETUP;
        end
      end
      // POLL is the address-setup phase of a busy-flag read; same timing as a write setup.
      SETUP, POLL: begin
        if (cnt_last) begin
          state_d = PULSE;
          e_d     = 1'b1;
          cnt_d   = LD_EN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_last) begin
          state_d = HOLD;
          e_d     = 1'b0;
          cnt_d   = LD_HOLD;
`ifdef LCD_BUSY_POLL_EN
          if (rd_q) stat_d = lcd_db_in[7];
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_last) begin
`ifdef LCD_BUSY_POLL_EN
          if (!rd_q || stat_q) begin
            state_d = POLL;
            cnt_d   = LD_SETUP;
            rd_d    = 1'b1;
            rw_d    = 1'b1;
            rs_d    = 1'b0;
            oe_d    = 1'b0;
          end else begin
            state_d      = IDLE;
            rd_d         = 1'b0;
            rw_d         = 1'b0;
            oe_d         = 1'b1;
            ack_d[gid_q] = 1'b1;
          end
`else
          state_d = EXEC;
          cnt_d   = long_q ? LD_EXEC_LONG : LD_EXEC;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EXEC: begin
        if (cnt_last) begin
          state_d      = IDLE;
          ack_d[gid_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef LCD_BUSY_POLL_EN
    // Timeout: a controller that never clears its busy flag is treated as ready.
    if (rd_q && (pcnt_q == LD_EXEC_LONG)) begin
      state_d      = IDLE;
      e_d          = 1'b0;
      rd_d         = 1'b0;
      rw_d         = 1'b0;
      oe_d         = 1'b1;
      ack_d        = 2'b00;
      ack_d[gid_q] = 1'b1;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      ack_q   <= 2'b00;
      gid_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      rd_q    <= 1'b0;
      stat_q  <= 1'b0;
      pcnt_q  <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b1;
`else
      long_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
`ifdef LCD_BUSY_POLL_EN
      rd_q    <= rd_d;
      stat_q  <= stat_d;
      pcnt_q  <= pcnt_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
`else
      long_q  <= long_d;
`endif
    end
  end

  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_db   = db_q;
`ifdef LCD_BUSY_POLL_EN
  assign lcd_rw    = rw_q;
  assign lcd_db_oe = oe_q;
`endif

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed self-checking bench for lcd_bus_scheduler with short timing parameters.
module tb_lcd_bus_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, rs0, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, busy, grant_id, lcd_e, lcd_rs;
  logic [7:0] lcd_db;
`ifdef LCD_BUSY_POLL_EN
  logic       lcd_rw, lcd_db_oe;
  logic [7:0] lcd_db_in;
`endif

  int checks = 0;
  int errors = 0;

  // Table of single-requester writes on req0: rs, data, expected ack edge index.
  logic [7:0] t_data [7] = '{8'h01, 8'h80, 8'h02, 8'h03, 8'h04, 8'h01, 8'h00};
  logic       t_rs   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int         t_lat  [7] = '{25, 13, 25, 25, 13, 13, 13};
  logic [1:0] rr_who [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  always #5 clk = ~clk;

  lcd_bus_scheduler #(
    .T_SETUP     (1),
    .T_EN_HIGH   (3),
    .T_HOLD      (1),
    .T_EXEC      (8),
    .T_EXEC_LONG (20),
    .CNT_W       (17)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .rs0       (rs0),
    .rs1       (rs1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .busy      (busy),
    .grant_id  (grant_id),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
`ifdef LCD_BUSY_POLL_EN
    .lcd_rw    (lcd_rw),
    .lcd_db_oe (lcd_db_oe),
    .lcd_db_in (lcd_db_in),
`endif
    .lcd_db    (lcd_db)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps edge by edge from a negedge; k=0 is the first rising edge (the grant edge when a
  // request is already pending). Stops at the first ack, bounded by max_k edges.
  task automatic observe(input int max_k, output int e_first, output int e_len,
                         output int ack_k, output logic [1:0] who, output logic busy0);
    e_first = -1;
    e_len   = 0;
    ack_k   = -1;
    who     = 2'b00;
    busy0   = 1'b0;
    for (int k = 0; k < max_k; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (lcd_e) begin
        if (e_first < 0) e_first = k;
        e_len++;
      end
      if (ack0 || ack1) begin
        ack_k = k;
        who   = {ack1, ack0};
        break;
      end
    end
  endtask

  int         e_first, e_len, ack_k;
  logic [1:0] who;
  logic       busy0;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
`ifdef LCD_BUSY_POLL_EN
    lcd_db_in = 8'h80;
`endif
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_lcd_e", lcd_e, 1'b0);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_db", lcd_db, 8'h00);
    check("rst_acks", {ack1, ack0}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 1'b1);
`ifdef LCD_BUSY_POLL_EN
    check("rst_lcd_rw", lcd_rw, 1'b0);
    check("rst_lcd_db_oe", lcd_db_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h48;
    begin
      int   rd_rise, rd_fall;
      logic prev_e;
      rd_rise = 0; rd_fall = 0; prev_e = 1'b0; ack_k = -1;
      for (int k = 0; k < 60; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (k == 6) begin
          check("poll_rw", lcd_rw, 1'b1);
          check("poll_oe", lcd_db_oe, 1'b0);
          check("poll_rs", lcd_rs, 1'b0);
        end
        if (lcd_e && !prev_e && lcd_rw) rd_rise++;
        if (!lcd_e && prev_e && lcd_rw) begin
          rd_fall++;
          if (rd_fall == 2) lcd_db_in = 8'h00;
        end
        prev_e = lcd_e;
        if (ack0 || ack1) begin
          ack_k = k;
          break;
        end
      end
      req0 = 1'b0;
      check("poll_read_strobes", rd_rise, 3);
      check("poll_ack_edge", ack_k, 20);
      check("poll_ack_who", {ack1, ack0}, 2'b01);
      check("poll_end_rw", lcd_rw, 1'b0);
      check("poll_end_oe", lcd_db_oe, 1'b1);
      check("poll_end_busy", busy, 1'b0);
    end
    @(negedge clk);
`else
    rst = 1'b1;
    @(negedge clk);

    // Single data write on req1.
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h41;
    observe(40, e_first, e_len, ack_k, who, busy0);
    req1 = 1'b0;
    check("t1_busy_after_grant", busy0, 1'b1);
    check("t1_e_first", e_first, 1);
    check("t1_e_len", e_len, 3);
    check("t1_ack_edge", ack_k, 13);
    check("t1_ack_who", who, 2'b10);
    check("t1_lcd_db", lcd_db, 8'h41);
    check("t1_lcd_rs", lcd_rs, 1'b1);
    check("t1_grant_id", grant_id, 1'b1);
    check("t1_busy_idle", busy, 1'b0);
    @(negedge clk);

    // Long vs normal execution wait on req0.
    for (int i = 0; i < 7; i++) begin
      req0 = 1'b1; rs0 = t_rs[i]; data0 = t_data[i];
      observe(60, e_first, e_len, ack_k, who, busy0);
      req0 = 1'b0;
      check($sformatf("tab%0d_ack_edge", i), ack_k, t_lat[i]);
      check($sformatf("tab%0d_ack_who", i), who, 2'b01);
      check($sformatf("tab%0d_lcd_db", i), lcd_db, t_data[i]);
      @(negedge clk);
    end
    check("tab_grant_id", grant_id, 1'b0);

    // Both requesting continuously: strict alternation, last grant was 0.
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'hAA;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h55;
    for (int i = 0; i < 4; i++) begin
      observe(40, e_first, e_len, ack_k, who, busy0);
      check($sformatf("rr%0d_who", i), who, rr_who[i]);
      check($sformatf("rr%0d_ack_edge", i), ack_k, 13);
      check($sformatf("rr%0d_lcd_db", i), lcd_db, rr_who[i][1] ? 8'h55 : 8'hAA);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Asynchronous reset while E is high; the still-pending request is granted after release.
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h33;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_e_before_rst", lcd_e, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_lcd_e", lcd_e, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_acks", {ack1, ack0}, 2'b00);
    check("mid_rst_grant_id", grant_id, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    observe(40, e_first, e_len, ack_k, who, busy0);
    req0 = 1'b0;
    check("regrant_e_first", e_first, 1);
    check("regrant_ack_edge", ack_k, 13);
    check("regrant_who", who, 2'b01);
    check("regrant_lcd_db", lcd_db, 8'h33);
    @(negedge clk);

    // Request withdrawn and data changed one cycle after grant.
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0; rs0 = 1'b0; data0 = 8'hC3;
    check("drop_lcd_db_latched", lcd_db, 8'h5A);
    observe(40, e_first, e_len, ack_k, who, busy0);
    check("drop_ack_edge", ack_k, 12);
    check("drop_ack_who", who, 2'b01);
    check("drop_lcd_db", lcd_db, 8'h5A);
    check("drop_lcd_rs", lcd_rs, 1'b1);
    @(negedge clk);
    check("idle_keep_db", lcd_db, 8'h5A);
    check("idle_busy", busy, 1'b0);
    check("idle_no_ack", {ack1, ack0}, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
